// File: rtl/hex_word_assembler_if.sv
// Character-in / word-out handshake bundle for hex_word_assembler.
// The block takes the slave side; whoever feeds characters and drains words takes master.
interface hex_word_assembler_if #(
   parameter int DIGITS = 4
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   logic          in_valid;
   logic          in_ready;
   logic [7:0]    chr_i;
   logic [3:0]    nib_i;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_word;
   logic [CW-1:0] out_ndig;
   logic          out_err;

   modport slave (
      input  in_valid, chr_i, nib_i, out_ready,
      output in_ready, out_valid, out_word, out_ndig, out_err
   );

   modport master (
      output in_valid, chr_i, nib_i, out_ready,
      input  in_ready, out_valid, out_word, out_ndig, out_err
   );
endinterface

// File: rtl/hex_word_assembler.sv
// Packs delimiter-terminated ASCII hex tokens into right-aligned words; malformed
// or over-long tokens are reported as a single error result.
module hex_word_assembler #(
   parameter int DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hex_word_assembler_if.slave  bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, SKIP, EMIT} state_t;

   state_t        r_state, w_state_nx;
   logic [W-1:0]  r_acc, w_acc_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic          r_err, w_err_nx;
   logic          w_take, w_is_hex, w_is_delim, w_emit;

   // Digit class comes from the character itself; nib_i is trusted only for digits.
   function automatic logic f_is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
   endfunction

   assign w_is_hex   = f_is_hex(bus.chr_i);
   assign w_is_delim = (bus.chr_i == 8'h20) || (bus.chr_i == 8'h2C) ||
                       (bus.chr_i == 8'h0D) || (bus.chr_i == 8'h0A);
   assign w_emit     = (r_state == EMIT);
   assign w_take     = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_acc <= w_acc_nx;
         r_cnt <= w_cnt_nx;
         r_err <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_acc_nx   = r_acc;
      w_cnt_nx   = r_cnt;
      w_err_nx   = r_err;
      case (r_state)
         IDLE: begin
            // Leading delimiters are swallowed so empty tokens never emit.
            if (w_take) begin
               if (w_is_hex) begin
                  w_acc_nx   = W'(bus.nib_i);
                  w_cnt_nx   = CW'(1);
                  w_state_nx = ACCUM;
               end else if (!w_is_delim) begin
                  w_state_nx = SKIP;
               end
            end
         end
         ACCUM: begin
            if (w_take) begin
               if (w_is_hex) begin
                  if (r_cnt == CW'(DIGITS)) begin
                     w_state_nx = SKIP;
                  end else begin
                     w_acc_nx = (r_acc << 4) | W'(bus.nib_i);
                     w_cnt_nx = r_cnt + CW'(1);
                  end
               end else if (w_is_delim) begin
                  w_err_nx   = 1'b0;
                  w_state_nx = EMIT;
               end else begin
                  w_state_nx = SKIP;
               end
            end
         end
         SKIP: begin
            if (w_take && w_is_delim) begin
               w_err_nx   = 1'b1;
               w_state_nx = EMIT;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               w_acc_nx   = '0;
               w_cnt_nx   = '0;
               w_err_nx   = 1'b0;
               w_state_nx = IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Error results carry no payload, so acc/cnt left over from SKIP are masked here.
   assign bus.in_ready  = !w_emit;
   assign bus.out_valid = w_emit;
   assign bus.out_err   = w_emit && r_err;
   assign bus.out_word  = (w_emit && !r_err) ? r_acc : '0;
   assign bus.out_ndig  = (w_emit && !r_err) ? r_cnt : '0;
endmodule
